// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: filtered deserializer plus make/break/E0 decode into a held-key view; 2-cycle stop-to-output latency, no backpressure.
// Define PS2_TYPEMATIC_FILTER_EN to skip register writes on typematic repeats and count them in repeat_count.
module ps2_keycode_rx #(
  parameter int          FILTER_LEN     = 4,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SPACE_CODE     = 8'h29
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       space,
  output logic       extended,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    BRK_CODE = 8'hF0;
  localparam logic [7:0]    EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          flt_clk, strobe, sdata;
  logic [FW-1:0] flt_cnt;
  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_ok;
  logic [TW-1:0] tmo_cnt;
  logic          timeout, byte_vld, err_c;
  logic [7:0]    byte_q;
  logic          byte_vld_q;
  logic          brk, ext;
  logic [7:0]    keycode_n;
  logic          space_n, extended_n, changed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // flt_cnt counts consecutive samples disagreeing with the filtered level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_clk <= 1'b1;
      flt_cnt <= '0;
      strobe  <= 1'b0;
      sdata   <= 1'b1;
    end else begin
      strobe <= 1'b0;
      if (clk_sync[1] == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        flt_clk <= clk_sync[1];
        flt_cnt <= '0;
        strobe  <= flt_clk;
        sdata   <= dat_sync[1];
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (strobe) begin
      case (state)
        IDLE:    if (!sdata) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    timeout  = (state != IDLE) && (tmo_cnt == TMO_LAST) && !strobe;
    byte_vld = (state == STOP) && strobe && sdata && parity_ok;
    err_c    = ((state == STOP) && strobe && !(sdata && parity_ok)) || timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift     <= '0;
      parity_ok <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      if (strobe || state == IDLE)  tmo_cnt <= '0;
      else if (tmo_cnt != '1)       tmo_cnt <= tmo_cnt + TW'(1);
      if (state == IDLE)                  bit_cnt <= '0;
      else if (state == DATA && strobe)   bit_cnt <= bit_cnt + 3'd1;
      if (state == DATA && strobe)        shift <= {sdata, shift[7:1]};
      if (state == PARITY && strobe)      parity_ok <= ^{sdata, shift};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      frame_err  <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
    end else begin
      byte_vld_q <= byte_vld;
      frame_err  <= err_c;
      if (byte_vld) byte_q <= shift;
      if (err_c) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (byte_vld_q) begin
        if (byte_q == BRK_CODE)      brk <= 1'b1;
        else if (byte_q == EXT_CODE) ext <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    keycode_n  = keycode;
    extended_n = extended;
    space_n    = space;
    if (byte_vld_q && byte_q != BRK_CODE && byte_q != EXT_CODE) begin
      if (!brk) begin
        if (byte_q == SPACE_CODE) begin
          space_n = 1'b1;
        end else begin
          keycode_n  = byte_q;
          extended_n = ext;
        end
      end else begin
        if (byte_q == SPACE_CODE) begin
          space_n = 1'b0;
        end else if (byte_q == keycode && ext == extended) begin
          keycode_n  = 8'h00;
          extended_n = 1'b0;
        end
      end
    end
    changed = (keycode_n != keycode) || (extended_n != extended) || (space_n != space);
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic        is_repeat;
  logic [15:0] repeat_count;

  always_comb begin
    is_repeat = 1'b0;
    if (byte_vld_q && !brk && byte_q != BRK_CODE && byte_q != EXT_CODE) begin
      if (byte_q == SPACE_CODE) is_repeat = space;
      else                      is_repeat = (byte_q == keycode) && (ext == extended);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keycode      <= '0;
      extended     <= 1'b0;
      space        <= 1'b0;
      key_valid    <= 1'b0;
      repeat_count <= '0;
    end else begin
      key_valid <= changed;
      if (is_repeat) begin
        if (repeat_count != 16'hFFFF) repeat_count <= repeat_count + 16'd1;
      end else begin
        keycode  <= keycode_n;
        extended <= extended_n;
        space    <= space_n;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keycode   <= '0;
      extended  <= 1'b0;
      space     <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= changed;
      keycode   <= keycode_n;
      extended  <= extended_n;
      space     <= space_n;
    end
  end
`endif

endmodule
